w_input_conditioner: RTL and testbench



---
 rtl/w_input_conditioner.sv | 164 ++++++++++++++++
 tb/tb_w_input_conditioner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/w_input_conditioner.sv
// Switch/push-button front end: synchronise, debounce, emit w level and step pulse.
// Optional build macro: KEY_AUTOREPEAT_EN (periodic step while the key stays pressed).

module w_input_conditioner_deb #(
    parameter int CNT_W           = 5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    output logic waiting,
    output logic commit
);
    typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        commit  = 1'b0;
        case (state)
            IDLE_LO: if (s) begin
                state_n = WAIT_HI;
                cnt_n   = CNT_W'(1);
            end
            WAIT_HI: if (!s) begin
                state_n = IDLE_LO;
            end else if (cnt == CNT_MAX) begin
                state_n = IDLE_HI;
                commit  = 1'b1;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            IDLE_HI: if (!s) begin
                state_n = WAIT_LO;
                cnt_n   = CNT_W'(1);
            end
            WAIT_LO: if (s) begin
                state_n = IDLE_HI;
            end else if (cnt == CNT_MAX) begin
                state_n = IDLE_LO;
                commit  = 1'b1;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            default: state_n = IDLE_LO;
        endcase
    end

    assign waiting = (state == WAIT_HI) || (state == WAIT_LO);
endmodule

module w_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    input  logic key_raw,
    output logic w,
    output logic step,
    output logic busy
);
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) <= DEBOUNCE_CYCLES
        || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("w_input_conditioner: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sw_sync, key_sync;
    logic                   sw_wait, key_wait, sw_commit, key_commit;
    logic                   key_lvl;

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_sync  <= '0;
            key_sync <= '0;
        end else begin
            sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_raw};
            key_sync <= {key_sync[SYNC_STAGES-2:0], key_raw};
        end
    end

    w_input_conditioner_deb #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_deb (
        .clk     (clk),
        .reset   (reset),
        .s       (sw_sync[SYNC_STAGES-1]),
        .waiting (sw_wait),
        .commit  (sw_commit)
    );

    w_input_conditioner_deb #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_deb (
        .clk     (clk),
        .reset   (reset),
        .s       (key_sync[SYNC_STAGES-1]),
        .waiting (key_wait),
        .commit  (key_commit)
    );

    assign busy = sw_wait | key_wait;

    // Committed levels are tracked by toggling on each commit; this matches the
    // FSM's IDLE_HI/WAIT_LO decode but keeps the levels as plain registers.
`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

    logic [RPT_W-1:0] rpt;
    logic             key_fall, rpt_fire;

    assign key_fall = key_commit & key_lvl;
    assign rpt_fire = key_lvl & ~key_fall & (rpt == RPT_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            w       <= 1'b0;
            key_lvl <= 1'b0;
            step    <= 1'b0;
            rpt     <= '0;
        end else begin
            w       <= w ^ sw_commit;
            key_lvl <= key_lvl ^ key_commit;
            step    <= (key_commit & ~key_lvl) | rpt_fire;
            if (!key_lvl || key_fall || rpt_fire)
                rpt <= '0;
            else
                rpt <= rpt + RPT_W'(1);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            w       <= 1'b0;
            key_lvl <= 1'b0;
            step    <= 1'b0;
        end else begin
            w       <= w ^ sw_commit;
            key_lvl <= key_lvl ^ key_commit;
            step    <= key_commit & ~key_lvl;
        end
    end
`endif
endmodule

// File: tb/tb_w_input_conditioner.sv
// Directed bench for w_input_conditioner with a run-length behavioural model.
// Build with KEY_AUTOREPEAT_EN defined to exercise the auto-repeat scenario.

module tb_w_input_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 3;
    localparam int REP  = 8;

    logic clk = 1'b0, reset = 1'b1, sw_raw = 1'b0, key_raw = 1'b0;
    logic w, step, busy;

    w_input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_raw  (sw_raw),
        .key_raw (key_raw),
        .w       (w),
        .step    (step),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Model: raw inputs delayed SYNC edges through a queue; a level commits once
    // the synchronised sample has differed from it on DEB consecutive edges.
    bit q_sw[$];
    bit q_key[$];
    bit lvl[2];
    int run[2];
    int since;
    bit m_w, m_step, m_busy;
    bit model_valid = 1'b0;

    task automatic model_edge();
        bit s[2];
        bit commit[2];
        if (reset) begin
            q_sw.delete();
            q_key.delete();
            for (int i = 0; i < SYNC; i++) begin
                q_sw.push_back(1'b0);
                q_key.push_back(1'b0);
            end
            lvl    = '{1'b0, 1'b0};
            run    = '{0, 0};
            since  = 0;
            m_step = 1'b0;
            model_valid = 1'b1;
        end else begin
            s[0] = q_sw.pop_front();
            s[1] = q_key.pop_front();
            q_sw.push_back(sw_raw);
            q_key.push_back(key_raw);
            for (int ch = 0; ch < 2; ch++) begin
                commit[ch] = 1'b0;
                if (s[ch] != lvl[ch]) begin
                    run[ch]++;
                    if (run[ch] == DEB) begin
                        commit[ch] = 1'b1;
                        run[ch] = 0;
                    end
                end else begin
                    run[ch] = 0;
                end
            end
            m_step = 1'b0;
            if (commit[1] && !lvl[1]) begin
                m_step = 1'b1;
                since  = 0;
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (commit[1] && lvl[1]) begin
                since = 0;
            end else if (lvl[1]) begin
                since++;
                if (since % REP == 0) m_step = 1'b1;
            end
`endif
            for (int ch = 0; ch < 2; ch++)
                if (commit[ch]) lvl[ch] = !lvl[ch];
        end
        m_w    = lvl[0];
        m_busy = (run[0] > 0) || (run[1] > 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    logic prev_step = 1'b0;
    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            check("model_w", w, m_w);
            check("model_step", step, m_step);
            check("model_busy", busy, m_busy);
            check("step_not_consecutive", step & prev_step, 1'b0);
        end
        prev_step = step;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic t4_exp(input int e);
`ifdef KEY_AUTOREPEAT_EN
        return (e == 5) || (e == 13) || (e == 21);
`else
        return (e == 5);
`endif
    endfunction

    initial begin
        int rises;
        int pulses;
        logic prev_w;

        // reset state
        reset = 1'b1;
        repeat (3) tick();
        check("reset_w", w, 1'b0);
        check("reset_step", step, 1'b0);
        check("reset_busy", busy, 1'b0);

        // 1: clean switch rise, commit on edge 5
        reset  = 1'b0;
        sw_raw = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("t1_w", w, e >= 5);
            check("t1_busy", busy, (e >= 2) && (e <= 4));
        end
        sw_raw = 1'b0;
        repeat (10) tick();
        check("t1_w_low_again", w, 1'b0);

        // 2: three-cycle glitch rejected
        sw_raw = 1'b1;
        repeat (3) tick();
        sw_raw = 1'b0;
        for (int e = 3; e < 13; e++) begin
            tick();
            check("t2_w", w, 1'b0);
        end
        check("t2_busy", busy, 1'b0);

        // 3: bounce 1,0,1 then held; commit on edge 7
        rises  = 0;
        prev_w = w;
        sw_raw = 1'b1;
        tick();
        sw_raw = 1'b0;
        tick();
        sw_raw = 1'b1;
        for (int e = 2; e <= 12; e++) begin
            tick();
            check("t3_w", w, e >= 7);
            if (w && !prev_w) rises++;
            prev_w = w;
        end
        check("t3_single_rise", rises == 1, 1'b1);
        sw_raw = 1'b0;
        repeat (12) tick();

        // 4: key held 20 cycles
        pulses  = 0;
        key_raw = 1'b1;
        for (int e = 0; e < 40; e++) begin
            if (e == 20) key_raw = 1'b0;
            tick();
            check("t4_step", step, t4_exp(e));
            if (step) pulses++;
        end
`ifdef KEY_AUTOREPEAT_EN
        check("t4_pulse_count", pulses == 3, 1'b1);
`else
        check("t4_pulse_count", pulses == 1, 1'b1);
`endif

        // 5: reset during a pending switch commit
        sw_raw = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("t5_w_in_reset", w, 1'b0);
        check("t5_busy_in_reset", busy, 1'b0);
        reset = 1'b0;
        for (int r = 0; r <= 7; r++) begin
            tick();
            check("t5_w", w, r >= 5);
        end
        sw_raw = 1'b0;
        repeat (12) tick();

`ifdef KEY_AUTOREPEAT_EN
        // 6: auto-repeat while held 30 cycles
        key_raw = 1'b1;
        for (int e = 0; e < 50; e++) begin
            if (e == 30) key_raw = 1'b0;
            tick();
            check("t6_step", step, (e == 5) || (e == 13) || (e == 21) || (e == 29));
        end
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
